// File: rtl/switch_input_port_pkg.sv
// Shared constants for the switch input port.
// State encodings double as the LED status value.
package switch_input_port_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    localparam logic [1:0] LOAD_LO = 2'd0;
    localparam logic [1:0] LOAD_HI = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

endpackage

// File: rtl/switch_input_port_btn_debouncer.sv
// Button synchroniser, debounce counter and press detector.
// Emits a one-cycle registered pulse on each accepted rising level.
module btn_debouncer
    import switch_input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ = sync2 != level;
    assign accept = differ && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // Only an accepted 0->1 change of the stable level is a press.
            press <= accept && sync2;
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                level <= sync2;
            end
        end
    end

endmodule

// File: rtl/switch_input_port.sv
// Assembles a 32-bit word from two switch loads and holds it
// for the processor until the IN handshake completes.
module switch_input_port
    import switch_input_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic        btn,
    input  logic        in_ready,
    output logic        in_valid,
    output logic [31:0] in_data,
    output logic [1:0]  status
);

    logic       press;
    logic [1:0] state;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .press(press)
    );

    assign status = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD_LO;
            in_valid <= 1'b0;
            in_data  <= '0;
        end else begin
            unique case (1'b1)
                (state == LOAD_LO): begin
                    if (press) begin
                        in_data[15:0] <= sw;
                        state         <= LOAD_HI;
                    end
                end
                (state == LOAD_HI): begin
                    if (press) begin
                        in_data[31:16] <= sw;
                        state          <= HOLD;
                        in_valid       <= 1'b1;
                    end
                end
                // Presses here are dropped, even on the handshake cycle.
                (state == HOLD): begin
                    if (in_ready) begin
                        in_valid <= 1'b0;
                        state    <= LOAD_LO;
                    end
                end
                default: begin
                    state    <= LOAD_LO;
                    in_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
